// File: rtl/ysyx_210544_if_stage.sv
// Instruction fetch stage: one 64-bit aligned read per instruction, one in flight.
// Define YSYX_210544_IF_PERF_CNT_EN to add fetch/stall performance counters.
module ysyx_210544_if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_done,
  input  logic        i_if_pc_jmp,
  input  logic [63:0] i_if_pc_jmpaddr,
  output logic        o_if_bus_req,
  output logic [63:0] o_if_bus_addr,
  input  logic        i_if_bus_ack,
  input  logic [63:0] i_if_bus_rdata,
  input  logic        i_if_bus_err,
  output logic        o_if_fetched_req,
  output logic [63:0] o_if_pc,
  output logic [31:0] o_if_inst,
`ifdef YSYX_210544_IF_PERF_CNT_EN
  output logic [63:0] o_if_fetch_cnt,
  output logic [63:0] o_if_stall_cnt,
`endif
  output logic        o_if_nocmt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [63:0] addr_q, addr_d;
  logic        fet_q, fet_d;
  logic [63:0] opc_q, opc_d;
  logic [31:0] inst_q, inst_d;
  logic        nocmt_q, nocmt_d;

  logic unused_jmpaddr_lsb;
  assign unused_jmpaddr_lsb = ^i_if_pc_jmpaddr[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    fet_d   = 1'b0;
    opc_d   = opc_q;
    inst_d  = inst_q;
    nocmt_d = nocmt_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        req_d   = 1'b1;
        addr_d  = {pc_q[63:3], 3'b000};
      end
      S_REQ: begin
        if (i_if_bus_ack) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
          fet_d   = 1'b1;
          opc_d   = pc_q;
          nocmt_d = i_if_bus_err;
          if (i_if_bus_err) inst_d = NOP;
          else if (pc_q[2]) inst_d = i_if_bus_rdata[63:32];
          else inst_d = i_if_bus_rdata[31:0];
        end
      end
      S_WAIT: begin
        if (i_if_done) begin
          state_d = S_REQ;
          // Redirect targets are forced to word alignment.
          pc_d    = i_if_pc_jmp ? {i_if_pc_jmpaddr[63:2], 2'b00}
                                : pc_q + 64'd4;
          req_d   = 1'b1;
          addr_d  = {pc_d[63:3], 3'b000};
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= 64'd0;
      fet_q   <= 1'b0;
      opc_q   <= 64'd0;
      inst_q  <= 32'd0;
      nocmt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      fet_q   <= fet_d;
      opc_q   <= opc_d;
      inst_q  <= inst_d;
      nocmt_q <= nocmt_d;
    end
  end

  assign o_if_bus_req     = req_q;
  assign o_if_bus_addr    = addr_q;
  assign o_if_fetched_req = fet_q;
  assign o_if_pc          = opc_q;
  assign o_if_inst        = inst_q;
  assign o_if_nocmt       = nocmt_q;

`ifdef YSYX_210544_IF_PERF_CNT_EN
  logic [63:0] fcnt_q, fcnt_d;
  logic [63:0] scnt_q, scnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    scnt_d = scnt_q;
    if (state_q == S_REQ) begin
      if (i_if_bus_ack) fcnt_d = fcnt_q + 64'd1;
      else scnt_d = scnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= 64'd0;
      scnt_q <= 64'd0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign o_if_fetch_cnt = fcnt_q;
  assign o_if_stall_cnt = scnt_q;
`endif

endmodule

// File: doc/ysyx_210544_if_stage.md
Name: ysyx_210544_if_stage

Overview:
- Instruction fetch stage. Holds the architectural PC and issues one 64-bit aligned read per instruction on the instruction bus.
- Extracts the 32-bit instruction word and hands it to decode with a one-cycle o_if_fetched_req pulse. It is the sending end of the fetched-request handshake.
- Fetches the next instruction only after the writeback stage signals completion of the current one (non-pipelined, one instruction in flight). Applies branch/jump redirects at that point.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first PC fetched after reset.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_if_done  input  1  current instruction retired; advance PC
- i_if_pc_jmp  input  1  redirect request, sampled with i_if_done
- i_if_pc_jmpaddr  input  64  redirect target
- o_if_bus_req  output  1  instruction bus read valid
- o_if_bus_addr  output  64  8-byte-aligned read address
- i_if_bus_ack  input  1  read data valid (single-cycle)
- i_if_bus_rdata  input  64  read data
- i_if_bus_err  input  1  bus error, qualified by ack
- o_if_fetched_req  output  1  one-cycle pulse: pc/inst/nocmt valid
- o_if_pc  output  64  PC of fetched instruction
- o_if_inst  output  32  fetched instruction
- o_if_nocmt  output  1  instruction must not be committed to difftest

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on the rising clk edge.
- Reset values:
  - state=S_BOOT; pc register=RESET_PC.
  - o_if_bus_req=0, o_if_bus_addr=0, o_if_fetched_req=0.
  - o_if_pc=0, o_if_inst=0, o_if_nocmt=0.
- FSM states and transitions:
  - S_BOOT → S_REQ unconditionally one cycle after reset deasserts.
  - S_REQ:
    - o_if_bus_req=1 and o_if_bus_addr={pc[63:3],3'b000}, both registered and held stable until ack.
    - On i_if_bus_ack: next edge sets o_if_pc=pc and o_if_fetched_req=1, and deasserts o_if_bus_req.
    - o_if_inst = pc[2] ? rdata[63:32] : rdata[31:0].
    - o_if_nocmt=0. State → S_WAIT.
  - S_WAIT:
    - o_if_fetched_req returns to 0 after exactly one cycle; o_if_pc/o_if_inst/o_if_nocmt held stable.
    - On i_if_done: pc ← i_if_pc_jmp ? {i_if_pc_jmpaddr[63:2],2'b00} : pc+4. State → S_REQ, so the next bus_req appears the following cycle.
- Latency: ack at cycle N → fetched_req high at N+1. done at cycle M → bus_req high at M+1.
- Bus error: ack with i_if_bus_err=1 → o_if_inst=32'h0000_0013 (NOP), o_if_nocmt=1; flow otherwise identical.
- Arithmetic: pc+4 is modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 → 0).
- Ignored inputs:
  - i_if_bus_ack outside S_REQ is ignored.
  - i_if_done outside S_WAIT is ignored.
  - i_if_pc_jmp without i_if_done is ignored.
- Zero-latency ack: ack in the first S_REQ cycle is legal and accepted.
- Reset mid-operation: rst in S_REQ drops o_if_bus_req on the next edge. Any ack arriving that same cycle is discarded, and fetching restarts from RESET_PC.

Optional Feature:
- Macro YSYX_210544_IF_PERF_CNT_EN.
- Defined: adds outputs o_if_fetch_cnt (64) and o_if_stall_cnt (64), both reset to 0.
  - fetch_cnt increments on each accepted ack.
  - stall_cnt increments every cycle in S_REQ without ack.
  - Both wrap modulo 2^64.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, bus acks 2 cycles after req with rdata=64'h0000_0093_0010_0513 → addr=0x8000_0000; fetched_req pulses once with pc=0x8000_0000, inst=32'h0010_0513, nocmt=0.
- i_if_done without jmp → next addr=0x8000_0000 (same doubleword); pc=0x8000_0004, inst=32'h0000_0093 (upper half).
- i_if_done with jmp=1, jmpaddr=0x8000_0106 → bus_addr=0x8000_0100, o_if_pc=0x8000_0104.
- Ack with err=1 → inst=32'h0000_0013, nocmt=1, fetched_req one cycle.
- Spurious ack/done while in wrong state, plus rst asserted during S_REQ with a concurrent ack → no fetched_req; restart at RESET_PC, bus_req low one cycle after rst.
- pc=64'hFFFF_FFFF_FFFF_FFFC, done → next pc=0, bus_addr=0.
